// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready elastic stage with registered in_ready and out_data.
// Optional stall counter enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage #(
  parameter int unsigned NN    = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [NN-1:0]    in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [NN-1:0]    out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NN-1:0]   main_q, main_d;
  logic [NN-1:0]   skid_q, skid_d;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            in_fire;

  // in_ready_q is low for the first edge after reset, so no word is taken then
  assign in_fire = in_valid && in_ready_q;

  // next-state and datapath selection
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (in_fire && out_ready) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // state, storage and registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // saturating count of cycles where a held word is not accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: queue model of the two-entry stage,
// expected words pushed on input transfer and compared on output transfer.
module tb_pipe_skid_stage;

  localparam int unsigned NN    = 16;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic [NN-1:0]    in_data;
  logic             in_ready;
  logic             out_valid;
  logic [NN-1:0]    out_data;
  logic             out_ready;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [NN-1:0]    sb[$];
  logic             m_rdy;
  logic [CNT_W-1:0] m_stall;

  pipe_skid_stage #(.NN(NN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    check("in_ready", 32'(in_ready), 32'(m_rdy));
    if (sb.size() != 0) check("out_data_head", 32'(out_data), 32'(sb[0]));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  // drive one cycle from a negedge, advance the model, then check at the next negedge
  task automatic tick(input logic iv, input logic [NN-1:0] id, input logic ordy);
    logic          in_fire;
    logic          out_fire;
    logic [NN-1:0] exp;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    in_fire   = iv && m_rdy;
    out_fire  = (sb.size() != 0) && ordy;
`ifdef PIPE_SKID_STALL_CNT_EN
    if ((sb.size() != 0) && !ordy && (m_stall != {CNT_W{1'b1}}))
      m_stall = m_stall + CNT_W'(1);
`endif
    if (out_fire) begin
      exp = sb.pop_front();
      check("out_xfer", 32'(out_data), 32'(exp));
    end
    if (in_fire) sb.push_back(id);
    m_rdy = (sb.size() < 2);
    @(negedge clk);
    check_state();
  endtask

  // asynchronous reset asserted mid-cycle, released on a negedge
  task automatic do_reset();
    #2 reset_n = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    sb.delete();
    m_rdy   = 1'b0;
    m_stall = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check_state();
  endtask

  initial begin
    logic [CNT_W-1:0] exp_stall;
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    m_rdy     = 1'b0;
    m_stall   = '0;
    @(negedge clk);
    do_reset();

    // first edge after release: in_ready rises, the offered word is not taken
    tick(1'b1, 16'hDEAD, 1'b1);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_no_xfer", 32'(out_valid), 32'd0);

    // back-to-back streaming
    for (int i = 1; i <= 8; i++) tick(1'b1, NN'(i), 1'b1);
    tick(1'b0, 16'h0000, 1'b1);
    check("stream_drained", 32'(out_valid), 32'd0);

    // backpressure fills the skid register
    tick(1'b1, 16'hA5A5, 1'b0);
    tick(1'b1, 16'h5A5A, 1'b0);
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold_data", 32'(out_data), 32'hA5A5);
    tick(1'b1, 16'h7777, 1'b0);
    check("bp_still_held", 32'(out_data), 32'hA5A5);
    tick(1'b0, 16'h0000, 1'b1);
    check("bp_second", 32'(out_data), 32'h5A5A);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    tick(1'b0, 16'h0000, 1'b1);
    check("bp_empty", 32'(out_valid), 32'd0);

    // stall counter over exactly five stalled cycles from a fresh reset
    do_reset();
    tick(1'b0, 16'h0000, 1'b0);
    tick(1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 16'h0000, 1'b0);
`ifdef PIPE_SKID_STALL_CNT_EN
    exp_stall = CNT_W'(5);
`else
    exp_stall = '0;
`endif
    check("stall_five", 32'(stall_cnt), 32'(exp_stall));
    tick(1'b0, 16'h0000, 1'b1);

    // reset while FULL: held words must never appear
    tick(1'b1, 16'h1111, 1'b0);
    tick(1'b1, 16'h2222, 1'b0);
    check("pre_rst_full", 32'(in_ready), 32'd0);
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b0, 16'h0000, 1'b1);

    // random handshakes
    for (int i = 0; i < 10000; i++)
      tick(1'($urandom_range(0, 1)), NN'($urandom), 1'($urandom_range(0, 1)));

    // drain whatever is left
    for (int i = 0; i < 4; i++) tick(1'b0, 16'h0000, 1'b1);
    check("final_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
